segment_scan_decoder: RTL and testbench

SEGMENT_SCAN_DECODER -- requirements
Module: segment_scan_decoder

---
 rtl/segment_scan_decoder.sv | 174 +++++++++++++++++
 tb/tb_segment_scan_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/segment_scan_decoder.sv
// segment_scan_decoder
// Watches a multiplexed, active-low 4-digit 7-segment display bus (an/seg).
// A digit is accepted once its {an, seg} pattern stays unchanged for
// STABLE_CYCLES consecutive cycles. Accepted digits collect into four
// capture slots. When all four have been seen, the frame is presented on a
// valid/ready output.
//
// Handshake: out_valid stays high, and digits/bad/blank stay frozen, until
// a cycle where out_valid && out_ready. That cycle transfers the frame.
// The one exception: a new frame that completes in that same transfer cycle
// replaces the old one, and out_valid stays high.
//
// Optional feature macro: SEG_BLANK_EN. When it is defined, the all-dark
// pattern 1111111 decodes as a legal blank digit (value 0, blank flag set).
// Without it that pattern is flagged bad, and blank reads as constant 0.
module segment_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] digits,
    output logic [3:0]  bad,
    output logic [3:0]  blank,
    output logic        overrun,
    output logic        state_dbg_o
);

    typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

    localparam logic [7:0] ACC_CNT = 8'(STABLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [10:0] sample_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d, mask_set;
    logic [15:0] slot_q, slot_d;
    logic [3:0]  slot_bad_q, slot_bad_d, slot_blank_q, slot_blank_d;
    logic [15:0] digits_q;
    logic [3:0]  bad_q, blank_q;
    logic        overrun_q;
    logic [3:0]  dig_sel;
    logic        accept, complete, load, set_ovr;
    logic [3:0]  dec_val;
    logic        dec_legal, dec_blank;

    // The counter measures how long sample_q has been unchanged, minus one.
    // It saturates so that a very long run can never wrap and fire again.
    always_comb begin
        cnt_d = 8'd0;
        if (({an, seg} == sample_q) && $onehot(~an))
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end

    assign dig_sel = ~sample_q[10:7];
    assign accept  = $onehot(dig_sel) && (cnt_q == ACC_CNT);

    // Segment pattern to hex value. Unknown patterns become value 0 and are flagged illegal.
    always_comb begin
        dec_val   = 4'h0;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        case (sample_q[6:0])
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001110: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
`ifdef SEG_BLANK_EN
            7'b1111111: dec_blank = 1'b1;
`endif
            default:    dec_legal = 1'b0;
        endcase
    end

    // Capture the accepted digit into its slot. The mask clears on the
    // same edge the completed frame is handed to the output logic.
    always_comb begin
        slot_d       = slot_q;
        slot_bad_d   = slot_bad_q;
        slot_blank_d = slot_blank_q;
        mask_set     = mask_q;
        if (accept) begin
            mask_set = mask_q | dig_sel;
            for (int i = 0; i < 4; i++) begin
                if (dig_sel[i]) begin
                    slot_d[4*i +: 4] = dec_val;
                    slot_bad_d[i]    = ~dec_legal;
                    slot_blank_d[i]  = dec_blank;
                end
            end
        end
        complete = accept && (mask_set == 4'hF);
        mask_d   = complete ? 4'h0 : mask_set;
    end

    // Output FSM: decide whether a completed frame is loaded, is dropped
    // (overrun), or whether the presented frame is released.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        set_ovr = 1'b0;
        case (state_q)
            COLLECT: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (complete) load = 1'b1;
                    else          state_d = COLLECT;
                end else if (complete) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State, sampling, and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            sample_q     <= '1;
            cnt_q        <= 8'd0;
            mask_q       <= 4'h0;
            slot_q       <= 16'h0;
            slot_bad_q   <= 4'h0;
            slot_blank_q <= 4'h0;
            digits_q     <= 16'h0;
            bad_q        <= 4'h0;
            blank_q      <= 4'h0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_q     <= {an, seg};
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            slot_q       <= slot_d;
            slot_bad_q   <= slot_bad_d;
            slot_blank_q <= slot_blank_d;
            overrun_q    <= overrun_q | set_ovr;
            if (load) begin
                digits_q <= slot_d;
                bad_q    <= slot_bad_d;
                blank_q  <= slot_blank_d;
            end
        end
    end

    assign out_valid   = (state_q == PRESENT);
    assign digits      = digits_q;
    assign bad         = bad_q;
    assign blank       = blank_q;
    assign overrun     = overrun_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Testbench for segment_scan_decoder. It uses a run-length reference model:
// a digit is accepted once its {an, seg} value has been driven for S
// identical cycles. Frames are assembled from those accepted digits.
module tb_segment_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] digits;
  logic [3:0]  bad, blank;
  logic        overrun, state_dbg;

  int checks = 0;
  int errors = 0;

  logic [6:0] codes [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001110,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // reference model state
  int          run;
  logic [10:0] m_prev;
  bit          m_pend;
  int          m_pend_idx;
  logic [3:0]  m_pend_val;
  bit          m_pend_bad, m_pend_blank;
  logic [3:0]  m_mask;
  logic [3:0]  m_slot [4];
  bit          m_sbad [4];
  bit          m_sblank [4];
  bit          m_pres, m_ovr;
  logic [15:0] m_dig;
  logic [3:0]  m_bad, m_blank;

  logic [15:0] last_digits;
  logic [3:0]  last_bad;

  segment_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .out_ready(out_ready),
    .out_valid(out_valid), .digits(digits), .bad(bad), .blank(blank),
    .overrun(overrun), .state_dbg_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run = 0; m_prev = 11'h7FF; m_pend = 0; m_mask = 4'h0;
    for (int i = 0; i < 4; i++) begin m_slot[i] = 4'h0; m_sbad[i] = 0; m_sblank[i] = 0; end
    m_pres = 0; m_ovr = 0; m_dig = 16'h0; m_bad = 4'h0; m_blank = 4'h0;
  endtask

  task automatic model_load();
    m_dig = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
    m_bad = {m_sbad[3], m_sbad[2], m_sbad[1], m_sbad[0]};
    m_blank = {m_sblank[3], m_sblank[2], m_sblank[1], m_sblank[0]};
  endtask

  // One rising edge of the reference model, using the inputs driven before that edge.
  task automatic model_edge(input logic [3:0] a, input logic [6:0] s, input logic r);
    bit complete;
    bit valid;
    bit found;
    complete = 0;
    if (m_pend) begin
      m_slot[m_pend_idx] = m_pend_val;
      m_sbad[m_pend_idx] = m_pend_bad;
      m_sblank[m_pend_idx] = m_pend_blank;
      m_mask = m_mask | (4'b1 << m_pend_idx);
      if (m_mask == 4'hF) begin complete = 1; m_mask = 4'h0; end
    end
    if (m_pres) begin
      if (r) begin
        if (complete) model_load(); else m_pres = 0;
      end else if (complete) m_ovr = 1;
    end else if (complete) begin
      model_load(); m_pres = 1;
    end
    valid = ($countones(~a) == 1);
    if (valid && ({a, s} == m_prev)) run++;
    else run = valid ? 1 : 0;
    m_prev = {a, s};
    m_pend = valid && (run == S);
    if (m_pend) begin
      for (int i = 0; i < 4; i++) if (a[i] == 1'b0) m_pend_idx = i;
      found = 0; m_pend_val = 4'h0; m_pend_blank = 0;
      for (int v = 0; v < 16; v++) if (codes[v] == s) begin found = 1; m_pend_val = 4'(v); end
`ifdef SEG_BLANK_EN
      if (s == 7'h7F) begin found = 1; m_pend_blank = 1; end
`endif
      m_pend_bad = !found;
    end
  endtask

  // driver: one cycle with the given inputs, then compare every output against the model
  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic r, input logic rs);
    an = a; seg = s; out_ready = r; rst = rs;
    @(posedge clk);
    if (rs) model_reset(); else model_edge(a, s, r);
    #1;
    check("out_valid", out_valid, m_pres);
    check("digits", digits, m_dig);
    check("bad", bad, m_bad);
    check("blank", blank, m_blank);
    check("overrun", overrun, m_ovr);
    if (out_valid) begin last_digits = digits; last_bad = bad; end
  endtask

  task automatic hold(input int d, input logic [6:0] s, input int n, input logic r);
    for (int k = 0; k < n; k++) step(~(4'b1 << d), s, r, 1'b0);
  endtask

  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++) step(4'hF, 7'h7F, r, 1'b0);
  endtask

  task automatic do_reset();
    step(4'hF, 7'h7F, 1'b0, 1'b1);
    step(4'hF, 7'h7F, 1'b0, 1'b1);
  endtask

  task automatic scan(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                      input logic [6:0] s0, input int n, input logic r);
    hold(3, s3, n, r); hold(2, s2, n, r); hold(1, s1, n, r); hold(0, s0, n, r);
  endtask

  initial begin
    int d, n;
    logic [6:0] s;
    logic [3:0] a;
    model_reset();
    last_digits = 16'h0; last_bad = 4'h0;
    do_reset();
    check("rst_valid", out_valid, 1'b0);
    check("rst_digits", digits, 16'h0);

    // plain 1234 scan, consumer always ready
    scan(codes[1], codes[2], codes[3], codes[4], 6, 1'b1);
    idle(3, 1'b1);
    check("f1234_digits", last_digits, 16'h1234);
    check("f1234_bad", last_bad, 4'h0);
    check("f1234_released", out_valid, 1'b0);

    // digit 0 held too briefly: the frame never completes
    do_reset();
    hold(3, codes[5], 6, 1'b1); hold(2, codes[6], 6, 1'b1); hold(1, codes[7], 6, 1'b1);
    hold(0, codes[8], 3, 1'b1); hold(3, codes[5], 6, 1'b1);
    idle(4, 1'b1);
    check("short_no_frame", out_valid, 1'b0);

    // illegal pattern on digit 2
    do_reset();
    scan(codes[5], 7'b1111110, codes[7], codes[9], 6, 1'b0);
    idle(2, 1'b0);
    check("illegal_nib2", digits[11:8], 4'h0);
    check("illegal_bad", bad, 4'b0100);
    check("illegal_frame", digits, 16'h5079);
    step(4'hF, 7'h7F, 1'b1, 1'b0);
    check("illegal_released", out_valid, 1'b0);

    // back-pressure: a second frame is dropped and overrun is flagged
    do_reset();
    scan(codes[10], codes[11], codes[12], codes[13], 6, 1'b0);
    scan(codes[0], codes[15], codes[0], codes[15], 6, 1'b0);
    idle(2, 1'b0);
    check("ovr_digits", digits, 16'hABCD);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_valid", out_valid, 1'b1);
    step(4'hF, 7'h7F, 1'b1, 1'b0);
    check("ovr_release", out_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    // two digits selected at once, then reset in the middle of a frame
    do_reset();
    for (int k = 0; k < 20; k++) step(4'b0011, codes[8], 1'b1, 1'b0);
    hold(3, codes[1], 6, 1'b0); hold(2, codes[1], 6, 1'b0);
    do_reset();
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ovr", overrun, 1'b0);
    scan(codes[9], codes[8], codes[7], codes[6], 6, 1'b0);
    idle(2, 1'b0);
    check("fresh_digits", digits, 16'h9876);
    check("fresh_bad", bad, 4'h0);

    // all-dark digit 3
    do_reset();
    scan(7'b1111111, codes[1], codes[2], codes[3], 6, 1'b0);
    idle(2, 1'b0);
    check("dark_digits", digits, 16'h0123);
`ifdef SEG_BLANK_EN
    check("dark_blank", blank, 4'b1000);
    check("dark_bad", bad, 4'b0000);
`else
    check("dark_blank", blank, 4'b0000);
    check("dark_bad", bad, 4'b1000);
`endif

    // randomized scanning against the model
    do_reset();
    for (int t = 0; t < 400; t++) begin
      d = $urandom_range(0, 3);
      a = ~(4'b1 << d);
      if ($urandom_range(0, 9) == 0) a = 4'($urandom_range(0, 15));
      s = codes[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) s = 7'($urandom_range(0, 127));
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) step(a, s, 1'($urandom_range(0, 3) == 0), 1'b0);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
